// File: rtl/vram_arbiter.sv
// Single-port screen RAM shared by the video fetcher (absolute priority) and the Z80 bridge.
// Optional stall counter enabled by defining VRAM_STALL_CNT_EN.
module vram_arbiter #(
   parameter int ADDR_W  = 13,
   parameter int DATA_W  = 8,
   parameter int STALL_W = 16
) (
   input  logic               clk_pix,
   input  logic               reset,
   input  logic               vid_rd,
   input  logic [ADDR_W-1:0]  vid_addr,
   output logic [DATA_W-1:0]  vid_data,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic [ADDR_W-1:0]  cpu_addr,
   input  logic [DATA_W-1:0]  cpu_wdata,
   output logic               cpu_ack,
   output logic [DATA_W-1:0]  cpu_rdata,
   output logic [STALL_W-1:0] stall_count
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_ACK  = 1'b1
   } state_t;

   state_t state_p0;
   state_t state_next;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   logic              cpu_go;
   logic              ram_we;
   logic              cpu_rd_go;
   logic [ADDR_W-1:0] ram_addr;

   // The CPU only gets the port on an idle cycle that video leaves free; reset suppresses it.
   always_comb begin
      cpu_go    = (state_p0 == S_IDLE) && cpu_req && !vid_rd && !reset;
      ram_we    = cpu_go && cpu_we;
      cpu_rd_go = cpu_go && !cpu_we;
      ram_addr  = vid_rd ? vid_addr : cpu_addr;
   end

   always_ff @(posedge clk_pix) begin
      if (reset) begin
         state_p0 <= S_IDLE;
      end else begin
         state_p0 <= state_next;
      end
   end

   always_comb begin
      state_next = state_p0;
      case (state_p0)
         S_IDLE:  if (cpu_go) state_next = S_ACK;
         S_ACK:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      cpu_ack = (state_p0 == S_ACK);
   end

   // RAM array: no reset, contents survive a reset pulse.
   always_ff @(posedge clk_pix) begin
      if (ram_we) begin
         mem[ram_addr] <= cpu_wdata;
      end
   end

   always_ff @(posedge clk_pix) begin
      if (reset) begin
         vid_data  <= '0;
         cpu_rdata <= '0;
      end else begin
         if (vid_rd) begin
            vid_data <= mem[ram_addr];
         end
         if (cpu_rd_go) begin
            cpu_rdata <= mem[ram_addr];
         end
      end
   end

`ifdef VRAM_STALL_CNT_EN
   logic               stall;
   logic [STALL_W-1:0] stall_cnt;

   always_comb begin
      stall = (state_p0 == S_IDLE) && cpu_req && vid_rd;
   end

   always_ff @(posedge clk_pix) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != {STALL_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign stall_count = stall_cnt;
`else
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: reset, CPU access, video latency, contention,
// fetch pattern with random CPU reads, reset mid-access and stall counter saturation.
module tb_vram_arbiter;

   localparam int ADDR_W  = 13;
   localparam int DATA_W  = 8;
   localparam int STALL_W = 4;

`ifdef VRAM_STALL_CNT_EN
   localparam int EXP_STALL5  = 5;
   localparam int EXP_STALLSAT = 15;
`else
   localparam int EXP_STALL5  = 0;
   localparam int EXP_STALLSAT = 0;
`endif

   logic               clk_pix = 1'b0;
   logic               reset;
   logic               vid_rd;
   logic [ADDR_W-1:0]  vid_addr;
   logic [DATA_W-1:0]  vid_data;
   logic               cpu_req;
   logic               cpu_we;
   logic [ADDR_W-1:0]  cpu_addr;
   logic [DATA_W-1:0]  cpu_wdata;
   logic               cpu_ack;
   logic [DATA_W-1:0]  cpu_rdata;
   logic [STALL_W-1:0] stall_count;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] model [0:15];
   logic       req_prev = 1'b0;

   vram_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .STALL_W(STALL_W)
   ) dut (
      .clk_pix    (clk_pix),
      .reset      (reset),
      .vid_rd     (vid_rd),
      .vid_addr   (vid_addr),
      .vid_data   (vid_data),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_ack    (cpu_ack),
      .cpu_rdata  (cpu_rdata),
      .stall_count(stall_count)
   );

   always #5 clk_pix = ~clk_pix;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_pix);
      #1;
   endtask

   // cpu_req must stay high until the cycle in which ack is shown.
   always @(posedge clk_pix) begin
      if (!reset && req_prev && !cpu_ack) begin
         chk("proto_req_held", {31'b0, cpu_req}, 32'd1);
      end
      req_prev <= cpu_req && !cpu_ack && !reset;
   end

   task automatic cpu_access(input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wd,
                             output logic [DATA_W-1:0] rd, output int lat);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wd;
      lat       = 0;
      while (lat < 50) begin
         step();
         lat++;
         if (cpu_ack) break;
      end
      if (!cpu_ack) chk("cpu_timeout", {31'b0, cpu_ack}, 32'd1);
      rd      = cpu_rdata;
      cpu_req = 1'b0;
      step();
   endtask

   task automatic vid_read(input logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] d);
      vid_rd   = 1'b1;
      vid_addr = addr;
      step();
      vid_rd   = 1'b0;
      d        = vid_data;
   endtask

   initial begin
      logic [DATA_W-1:0] rd;
      logic [DATA_W-1:0] exp_vid;
      int lat;
      int nreq;
      int nack;

      reset = 1'b1; vid_rd = 1'b0; vid_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      step(); step();
      chk("rst_vid_data", vid_data, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_stall", stall_count, 0);
      reset = 1'b0;
      step();

      // Write/readback
      cpu_access(1'b1, 13'h1800, 8'hA5, rd, lat);
      chk("wr_lat", lat, 1);
      chk("ack_low_after", cpu_ack, 0);
      cpu_access(1'b0, 13'h1800, 8'h00, rd, lat);
      chk("rd_lat", lat, 1);
      chk("rd_data", rd, 8'hA5);

      // Video latency and hold
      cpu_access(1'b1, 13'h0000, 8'h3C, rd, lat);
      vid_read(13'h0000, rd);
      chk("vid_lat", rd, 8'h3C);
      vid_addr = 13'h0005;
      step(); step();
      chk("vid_hold", vid_data, 8'h3C);
      vid_read(13'h1800, rd);
      chk("vid_attr", rd, 8'hA5);

      // Contention: five stalled edges, write on the sixth
      vid_rd = 1'b1; vid_addr = 13'h1800;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0010; cpu_wdata = 8'h55;
      for (int i = 1; i <= 5; i++) begin
         step();
         chk("cont_no_ack", cpu_ack, 0);
      end
      vid_rd = 1'b0;
      step();
      chk("cont_ack", cpu_ack, 1);
      chk("cont_stall", stall_count, EXP_STALL5);
      cpu_req = 1'b0;
      step();
      chk("cont_ack_drop", cpu_ack, 0);
      vid_read(13'h0010, rd);
      chk("cont_wdata", rd, 8'h55);

      // Hazard: old value before the write edge, new value after it
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0010; cpu_wdata = 8'h99;
      vid_rd = 1'b1; vid_addr = 13'h0010;
      step();
      chk("haz_old", vid_data, 8'h55);
      vid_rd = 1'b0;
      step();
      chk("haz_ack", cpu_ack, 1);
      chk("haz_still_old", vid_data, 8'h55);
      cpu_req = 1'b0;
      vid_rd = 1'b1;
      step();
      vid_rd = 1'b0;
      chk("haz_new", vid_data, 8'h99);

      // Video fetch pattern with random CPU reads
      for (int i = 0; i < 16; i++) begin
         model[i] = 8'(i * 7 + 3);
         cpu_access(1'b1, 13'h0200 + 13'(i), model[i], rd, lat);
      end
      vid_read(13'h0200, rd);
      exp_vid = model[0];
      chk("pat_first", rd, exp_vid);
      nreq = 0; nack = 0;
      for (int hc = 0; hc < 64; hc++) begin
         logic       rd_now;
         logic [3:0] a;
         rd_now   = ((hc % 16) == 10) || ((hc % 16) == 12);
         a        = 4'((hc / 4) % 16);
         vid_rd   = rd_now;
         vid_addr = 13'h0200 + 13'(a);
         if (!cpu_req && ($urandom_range(0, 1) == 1)) begin
            cpu_req  = 1'b1;
            cpu_we   = 1'b0;
            cpu_addr = 13'h0200 + 13'($urandom_range(0, 15));
            nreq++;
         end
         step();
         if (rd_now) exp_vid = model[a];
         chk("pat_vid", vid_data, exp_vid);
         if (cpu_ack) begin
            nack++;
            chk("pat_ack_req", cpu_req, 1);
            chk("pat_rdata", cpu_rdata, model[cpu_addr[3:0]]);
            cpu_req = 1'b0;
         end
      end
      vid_rd = 1'b0;
      for (int k = 0; k < 10 && cpu_req; k++) begin
         step();
         if (cpu_ack) begin
            nack++;
            chk("pat_rdata", cpu_rdata, model[cpu_addr[3:0]]);
            cpu_req = 1'b0;
         end
      end
      cpu_req = 1'b0;
      step();
      chk("pat_acks", nack, nreq);
      chk("pat_idle_ack", cpu_ack, 0);

      // Reset during the ACK cycle of a write
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0100; cpu_wdata = 8'h77;
      step();
      chk("rmid_ack", cpu_ack, 1);
      reset = 1'b1; cpu_req = 1'b0;
      step();
      chk("rmid_no_ack", cpu_ack, 0);
      chk("rmid_vid", vid_data, 0);
      chk("rmid_rdata", cpu_rdata, 0);
      chk("rmid_stall", stall_count, 0);
      reset = 1'b0;
      step();
      chk("rmid_still_no_ack", cpu_ack, 0);
      cpu_access(1'b0, 13'h0100, 8'h00, rd, lat);
      chk("rmid_kept", rd, 8'h77);

      // Stall counter saturation
      vid_rd = 1'b1; vid_addr = 13'h0200;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0100;
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 9) chk("sat_mid", stall_count, (EXP_STALLSAT != 0) ? 10 : 0);
      end
      chk("sat_stall", stall_count, EXP_STALLSAT);
      chk("sat_no_ack", cpu_ack, 0);
      vid_rd = 1'b0;
      step();
      chk("sat_ack", cpu_ack, 1);
      chk("sat_rdata", cpu_rdata, 8'h77);
      chk("sat_hold", stall_count, EXP_STALLSAT);
      cpu_req = 1'b0;
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
